// File: rtl/hci_core_mux_static_sel.sv
// Switch controller for a static TCDM mux: tracks outstanding transactions on the
// master side and only changes the mux selection once all in-flight responses are back.
//
// state  | meaning
// RUN    | selection stable, requests pass, waiting for a switch request
// DRAIN  | requests gated, waiting for outstanding count to reach zero
// SWITCH | new selection applied this cycle, switch_gnt_o high
module hci_core_mux_static_sel #(
  parameter int unsigned NB_CHAN         = 2,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned RESET_SEL       = 0,
  localparam int unsigned SW = (NB_CHAN > 1) ? $clog2(NB_CHAN) : 1,
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          switch_req_i,
  input  logic [SW-1:0] switch_sel_i,
  output logic          switch_gnt_o,
  input  logic          tcdm_req_i,
  input  logic          tcdm_gnt_i,
  input  logic          tcdm_r_valid_i,
  output logic [SW-1:0] sel_o,
  output logic          gate_o,
  output logic          busy_o,
  output logic [CW-1:0] outstanding_o,
  output logic          err_o
);

  typedef enum logic [1:0] {RUN, DRAIN, SWITCH} state_e;

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] SEL_RST = SW'(RESET_SEL);

  state_e        state_q;
  logic [SW-1:0] sel_q;
  logic [SW-1:0] target_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          cnt_err;
  logic          gate_q;
  logic          gnt_q;
  logic          err_q;
  logic          handshake;
  logic          target_ok;

  assign handshake = tcdm_req_i & tcdm_gnt_i;

  // A simultaneous handshake and response cancel out, even at the limits.
  always_comb begin
    cnt_d   = cnt_q;
    cnt_err = 1'b0;
    if (handshake && !tcdm_r_valid_i) begin
      if (cnt_q == CNT_MAX) cnt_err = 1'b1;
      else                  cnt_d   = cnt_q + 1'b1;
    end else if (tcdm_r_valid_i && !handshake) begin
      if (cnt_q == '0) cnt_err = 1'b1;
      else             cnt_d   = cnt_q - 1'b1;
    end
  end

  // When NB_CHAN fills the select field every target encoding is a valid channel.
  if (NB_CHAN == (1 << SW)) begin : g_full_range
    assign target_ok = 1'b1;
  end else begin : g_part_range
    assign target_ok = (target_q < SW'(NB_CHAN));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= RUN;
      sel_q    <= SEL_RST;
      target_q <= SEL_RST;
      cnt_q    <= '0;
      gate_q   <= 1'b0;
      gnt_q    <= 1'b0;
      err_q    <= 1'b0;
    end else if (clear_i) begin
      state_q  <= RUN;
      sel_q    <= SEL_RST;
      target_q <= SEL_RST;
      cnt_q    <= '0;
      gate_q   <= 1'b0;
      gnt_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      gnt_q <= 1'b0;
      if (cnt_err) err_q <= 1'b1;
      case (state_q)
        RUN: begin
          if (switch_req_i) begin
            target_q <= switch_sel_i;
            state_q  <= DRAIN;
            gate_q   <= 1'b1;
          end
        end
        DRAIN: begin
          // A handshake that slipped past the gate this cycle keeps us draining.
          if (cnt_q == '0 && !handshake) begin
            state_q <= SWITCH;
            gnt_q   <= 1'b1;
            if (target_ok) sel_q <= target_q;
            else           err_q <= 1'b1;
          end
        end
        SWITCH: begin
          state_q <= RUN;
          gate_q  <= 1'b0;
        end
        default: begin
          state_q <= RUN;
          gate_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sel_o         = sel_q;
  assign gate_o        = gate_q;
  assign busy_o        = gate_q;
  assign switch_gnt_o  = gnt_q;
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

endmodule
